// File: rtl/rx_data_checker_pkg.sv
// Shared PN test-data definitions, common to the transmit generator
// and the receive checker.
package rx_data_checker_pkg;

    localparam int PN5_LEN   = 5;
    localparam int PN5_TAP_A = 5;
    localparam int PN5_TAP_B = 3;
    localparam int PN4_LEN   = 4;
    localparam int PN4_TAP_A = 4;
    localparam int PN4_TAP_B = 3;

    localparam logic [15:0] DEFAULT_PAYLOAD_LEN = 16'd128;

    typedef enum logic [1:0] {
        MODE_BPSK = 2'd0,
        MODE_QPSK = 2'd1,
        MODE_MIX  = 2'd2
    } mode_e;

    typedef enum logic {
        IDLE,
        IN_PKT
    } pkt_state_e;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rx_data_checker_if.sv
// AXIS payload stream: MSB lane PN5, LSB lane PN5/PN4, tuser = is_bpsk.
interface rx_data_checker_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic            tuser;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/rx_data_checker_pn_sync_checker.sv
// Self-synchronising PN checker: predicts each bit from received history
// and tracks lock from consecutive match / mismatch runs.
module pn_sync_checker
    import rx_data_checker_pkg::*;
#(
    parameter int N          = 5,
    parameter int TAP_A      = 5,
    parameter int TAP_B      = 3,
    parameter int LOCK_LEN   = 16,
    parameter int UNLOCK_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_in,
    output logic valid,
    output logic mismatch,
    output logic lock
);
    localparam int FW   = $clog2(N + 1);
    localparam int RMAX = (LOCK_LEN > UNLOCK_LEN) ? LOCK_LEN : UNLOCK_LEN;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [FW-1:0] FULL        = FW'(N);
    localparam logic [RW-1:0] LOCK_LAST   = RW'(LOCK_LEN - 1);
    localparam logic [RW-1:0] UNLOCK_LAST = RW'(UNLOCK_LEN - 1);

    logic [N-1:0]  hist;
    logic [FW-1:0] fill;
    logic [RW-1:0] run, run_d;
    lock_state_e   st, st_d;
    logic          pred;

    // hist[0] is the newest bit, so hist[k] is k+1 beats ago
    assign pred     = hist[TAP_A-1] ^ hist[TAP_B-1];
    assign valid    = en && (fill == FULL);
    assign mismatch = valid && (bit_in != pred);
    assign lock     = (st == LOCKED);

    always_comb begin
        st_d  = st;
        run_d = run;
        if (valid) begin
            unique case (st)
                UNLOCKED: begin
                    if (mismatch) begin
                        run_d = '0;
                    end else if (run == LOCK_LAST) begin
                        st_d  = LOCKED;
                        run_d = '0;
                    end else begin
                        run_d = run + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!mismatch) begin
                        run_d = '0;
                    end else if (run == UNLOCK_LAST) begin
                        st_d  = UNLOCKED;
                        run_d = '0;
                    end else begin
                        run_d = run + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            run  <= '0;
            st   <= UNLOCKED;
        end else begin
            st  <= st_d;
            run <= run_d;
            if (en) begin
                hist <= {hist[N-2:0], bit_in};
                if (fill != FULL)
                    fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_data_checker.sv
// Receive-side PSK test-data sink: PN sync checking, lane consistency,
// packet length and BER / packet statistics.
module rx_data_checker
    import rx_data_checker_pkg::*;
#(
    parameter int BYTES      = 1,
    parameter int LOCK_LEN   = 16,
    parameter int UNLOCK_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] payload_length,
    rx_data_checker_if.slave data,
    output logic        lock_5,
    output logic        lock_4,
    output logic [31:0] bit_cnt,
    output logic [31:0] bit_err_cnt,
    output logic [15:0] sym_err_cnt,
    output logic [15:0] pkt_cnt,
    output logic [15:0] pkt_err_cnt,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        len_err
);
    localparam int BITS = BYTES * 8;

    logic acc, b5, b4, sym_bad;
    logic v5, m5, v4, m4, beat_bad;
    logic [1:0]  binc, einc;
    logic [32:0] bit_sum, err_sum;

    pkt_state_e  st, st_d;
    logic [15:0] cnt, cnt_d, plen, plen_d;
    logic mode, mode_d, perr, perr_d, lbad, lbad_d;
    logic len_err_d, done_d, ok_d, final_bad;

    assign acc = data.tvalid & data.tready;
    assign b5  = data.tdata[BITS-1];
    assign b4  = data.tdata[0];

    if (BITS > 1) begin : g_sym
        logic [BITS-2:0] up;
        assign up      = data.tdata[BITS-1:1];
        assign sym_bad = ~((&up) | ~(|up)) | (data.tuser & (b4 ^ b5));
    end else begin : g_nosym
        assign sym_bad = 1'b0;
    end

    pn_sync_checker #(
        .N(PN5_LEN), .TAP_A(PN5_TAP_A), .TAP_B(PN5_TAP_B),
        .LOCK_LEN(LOCK_LEN), .UNLOCK_LEN(UNLOCK_LEN)
    ) u_pn5 (
        .clk(clk), .rst(rst), .en(acc), .bit_in(b5),
        .valid(v5), .mismatch(m5), .lock(lock_5)
    );

    // PN4 only advances on QPSK beats
    pn_sync_checker #(
        .N(PN4_LEN), .TAP_A(PN4_TAP_A), .TAP_B(PN4_TAP_B),
        .LOCK_LEN(LOCK_LEN), .UNLOCK_LEN(UNLOCK_LEN)
    ) u_pn4 (
        .clk(clk), .rst(rst), .en(acc & ~data.tuser), .bit_in(b4),
        .valid(v4), .mismatch(m4), .lock(lock_4)
    );

    assign binc     = {1'b0, v5 & lock_5} + {1'b0, v4 & lock_4};
    assign einc     = {1'b0, m5 & lock_5} + {1'b0, m4 & lock_4};
    assign beat_bad = sym_bad | (m5 & lock_5) | (m4 & lock_4);
    assign bit_sum  = {1'b0, bit_cnt} + {31'd0, binc};
    assign err_sum  = {1'b0, bit_err_cnt} + {31'd0, einc};

    always_comb begin
        st_d      = st;
        cnt_d     = cnt;
        plen_d    = plen;
        mode_d    = mode;
        perr_d    = perr;
        lbad_d    = lbad;
        len_err_d = len_err;
        ok_d      = pkt_ok;
        done_d    = 1'b0;
        final_bad = 1'b0;
        if (acc) begin
            unique case (st)
                IDLE: begin
                    st_d   = IN_PKT;
                    cnt_d  = 16'd1;
                    plen_d = payload_length;
                    mode_d = data.tuser;
                    perr_d = beat_bad;
                    lbad_d = 1'b0;
                end
                IN_PKT: begin
                    cnt_d  = sat_inc16(cnt);
                    perr_d = perr | beat_bad | (data.tuser != mode);
                    if (cnt == plen) begin
                        lbad_d    = 1'b1;
                        len_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
            if (data.tlast) begin
                final_bad = lbad_d | (cnt_d != plen_d);
                st_d      = IDLE;
                done_d    = 1'b1;
                len_err_d = final_bad;
                ok_d      = ~(perr_d | final_bad);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data.tready <= 1'b0;
            st          <= IDLE;
            cnt         <= '0;
            plen        <= '0;
            mode        <= 1'b0;
            perr        <= 1'b0;
            lbad        <= 1'b0;
            len_err     <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_ok      <= 1'b0;
        end else begin
            data.tready <= 1'b1;
            st          <= st_d;
            cnt         <= cnt_d;
            plen        <= plen_d;
            mode        <= mode_d;
            perr        <= perr_d;
            lbad        <= lbad_d;
            len_err     <= len_err_d;
            pkt_done    <= done_d;
            pkt_ok      <= ok_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            bit_err_cnt <= '0;
            sym_err_cnt <= '0;
            pkt_cnt     <= '0;
            pkt_err_cnt <= '0;
        end else if (clear) begin
            bit_cnt     <= '0;
            bit_err_cnt <= '0;
            sym_err_cnt <= '0;
            pkt_cnt     <= '0;
            pkt_err_cnt <= '0;
        end else begin
            bit_cnt     <= bit_sum[32] ? '1 : bit_sum[31:0];
            bit_err_cnt <= err_sum[32] ? '1 : err_sum[31:0];
            if (acc && sym_bad)
                sym_err_cnt <= sat_inc16(sym_err_cnt);
            if (done_d)
                pkt_cnt <= sat_inc16(pkt_cnt);
            if (done_d && !ok_d)
                pkt_err_cnt <= sat_inc16(pkt_err_cnt);
        end
    end

endmodule

// File: tb/tb_rx_data_checker.sv
// Directed bench for rx_data_checker: PN streams built from local
// generators, expected counts hand-computed per scenario.
module tb_rx_data_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [15:0] payload_length;
    logic        lock_5, lock_4;
    logic [31:0] bit_cnt, bit_err_cnt;
    logic [15:0] sym_err_cnt, pkt_cnt, pkt_err_cnt;
    logic        pkt_done, pkt_ok, len_err;

    int checks = 0;
    int errors = 0;

    logic [4:0] g5;
    logic [3:0] g4;

    rx_data_checker_if #(.BITS(8)) data_if ();

    rx_data_checker #(
        .BYTES(1), .LOCK_LEN(16), .UNLOCK_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .payload_length(payload_length),
        .data(data_if),
        .lock_5(lock_5),
        .lock_4(lock_4),
        .bit_cnt(bit_cnt),
        .bit_err_cnt(bit_err_cnt),
        .sym_err_cnt(sym_err_cnt),
        .pkt_cnt(pkt_cnt),
        .pkt_err_cnt(pkt_err_cnt),
        .pkt_done(pkt_done),
        .pkt_ok(pkt_ok),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    function automatic logic step5();
        logic nb;
        nb = g5[4] ^ g5[2];
        g5 = {g5[3:0], nb};
        return nb;
    endfunction

    function automatic logic step4();
        logic nb;
        nb = g4[3] ^ g4[2];
        g4 = {g4[2:0], nb};
        return nb;
    endfunction

    task automatic put(input logic [7:0] d, input logic u, input logic l);
        data_if.tdata  = d;
        data_if.tuser  = u;
        data_if.tlast  = l;
        data_if.tvalid = 1'b1;
        @(posedge clk);
        #1;
        data_if.tvalid = 1'b0;
        data_if.tlast  = 1'b0;
    endtask

    task automatic send(input int n, input logic u, input logic l,
                        input logic gaps);
        logic b5, b4;
        logic [7:0] d;
        int k;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                k = $urandom_range(0, 2);
                repeat (k) begin
                    @(posedge clk);
                    #1;
                end
            end
            b5 = step5();
            d  = {8{b5}};
            if (!u) begin
                b4   = step4();
                d[0] = b4;
            end
            put(d, u, l && (i == n - 1));
        end
    endtask

    task automatic send_flip();
        logic b5;
        logic [7:0] d;
        b5   = step5();
        d    = {8{b5}};
        d[7] = ~b5;
        put(d, 1'b1, 1'b0);
    endtask

    task automatic send_sym();
        logic b5, b4;
        logic [7:0] d;
        b5 = step5();
        b4 = step4();
        d  = {b5, ~b5, b5, b5, ~b5, b5, b5, b4};
        put(d, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        clear          = 1'b0;
        payload_length = 16'd128;
        data_if.tvalid = 1'b0;
        data_if.tlast  = 1'b0;
        data_if.tuser  = 1'b0;
        data_if.tdata  = 8'h00;
        g5 = 5'b00001;
        g4 = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_if.tready !== 1'b0) begin
            errors++; $display("FAIL reset_tready got %0b exp 0", data_if.tready);
        end
        checks++;
        if ({bit_cnt, pkt_cnt, lock_5, lock_4, pkt_done, pkt_ok} !== '0) begin
            errors++; $display("FAIL reset_state got bit %0d pkt %0d l5 %0b l4 %0b exp 0",
                               bit_cnt, pkt_cnt, lock_5, lock_4);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (data_if.tready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %0b exp 1", data_if.tready);
        end
    endtask

    task automatic test_clean_bpsk();
        send(20, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lock_5 !== 1'b0) begin
            errors++; $display("FAIL lock5_beat20 got %0b exp 0", lock_5);
        end
        send(1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lock_5 !== 1'b1 || bit_cnt !== 32'd0) begin
            errors++; $display("FAIL lock5_beat21 got %0b bit %0d exp 1 bit 0", lock_5, bit_cnt);
        end
        send(107, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL clean_pkt1 got done %0b ok %0b cnt %0d exp 1 1 1",
                               pkt_done, pkt_ok, pkt_cnt);
        end
        checks++;
        if (bit_cnt !== 32'd107 || bit_err_cnt !== 32'd0 || sym_err_cnt !== 16'd0) begin
            errors++; $display("FAIL clean_bits got %0d/%0d/%0d exp 107/0/0",
                               bit_cnt, bit_err_cnt, sym_err_cnt);
        end
        checks++;
        if (lock_4 !== 1'b0 || len_err !== 1'b0) begin
            errors++; $display("FAIL clean_l4_len got %0b %0b exp 0 0", lock_4, len_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pkt_done !== 1'b0 || pkt_ok !== 1'b1) begin
            errors++; $display("FAIL done_pulse got done %0b ok %0b exp 0 1", pkt_done, pkt_ok);
        end
        send(128, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pkt_cnt !== 16'd2 || bit_cnt !== 32'd235 || pkt_ok !== 1'b1) begin
            errors++; $display("FAIL clean_pkt2 got cnt %0d bit %0d ok %0b exp 2 235 1",
                               pkt_cnt, bit_cnt, pkt_ok);
        end
    endtask

    task automatic test_bit_flip();
        send(59, 1'b1, 1'b0, 1'b0);
        send_flip();
        checks++;
        if (bit_err_cnt !== 32'd1 || sym_err_cnt !== 16'd1) begin
            errors++; $display("FAIL flip_beat got err %0d sym %0d exp 1 1",
                               bit_err_cnt, sym_err_cnt);
        end
        send(68, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bit_err_cnt !== 32'd3 || sym_err_cnt !== 16'd1 || lock_5 !== 1'b1) begin
            errors++; $display("FAIL flip_total got err %0d sym %0d l5 %0b exp 3 1 1",
                               bit_err_cnt, sym_err_cnt, lock_5);
        end
        checks++;
        if (pkt_ok !== 1'b0 || pkt_err_cnt !== 16'd1 || pkt_cnt !== 16'd3) begin
            errors++; $display("FAIL flip_pkt got ok %0b perr %0d cnt %0d exp 0 1 3",
                               pkt_ok, pkt_err_cnt, pkt_cnt);
        end
        checks++;
        if (bit_cnt !== 32'd363) begin
            errors++; $display("FAIL flip_bit_cnt got %0d exp 363", bit_cnt);
        end
    endtask

    task automatic test_length();
        send(100, 1'b1, 1'b1, 1'b0);
        checks++;
        if (len_err !== 1'b1 || pkt_ok !== 1'b0 || pkt_err_cnt !== 16'd2) begin
            errors++; $display("FAIL short_pkt got len %0b ok %0b perr %0d exp 1 0 2",
                               len_err, pkt_ok, pkt_err_cnt);
        end
        send(64, 1'b1, 1'b0, 1'b0);
        checks++;
        if (len_err !== 1'b1) begin
            errors++; $display("FAIL len_sticky got %0b exp 1", len_err);
        end
        send(64, 1'b1, 1'b1, 1'b0);
        checks++;
        if (len_err !== 1'b0 || pkt_ok !== 1'b1 || pkt_cnt !== 16'd5) begin
            errors++; $display("FAIL len_recover got len %0b ok %0b cnt %0d exp 0 1 5",
                               len_err, pkt_ok, pkt_cnt);
        end
        send(128, 1'b1, 1'b0, 1'b0);
        checks++;
        if (len_err !== 1'b0) begin
            errors++; $display("FAIL long_beat128 got %0b exp 0", len_err);
        end
        send(1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (len_err !== 1'b1) begin
            errors++; $display("FAIL long_beat129 got %0b exp 1", len_err);
        end
        send(1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pkt_ok !== 1'b0 || pkt_err_cnt !== 16'd3 || pkt_cnt !== 16'd6) begin
            errors++; $display("FAIL long_pkt got ok %0b perr %0d cnt %0d exp 0 3 6",
                               pkt_ok, pkt_err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        send(50, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (data_if.tready !== 1'b0 || lock_5 !== 1'b0 || lock_4 !== 1'b0) begin
            errors++; $display("FAIL midrst_ready_lock got %0b %0b %0b exp 0 0 0",
                               data_if.tready, lock_5, lock_4);
        end
        checks++;
        if ({bit_cnt, bit_err_cnt, sym_err_cnt, pkt_cnt, pkt_err_cnt, len_err, pkt_ok} !== '0) begin
            errors++; $display("FAIL midrst_counters got bit %0d err %0d pkt %0d perr %0d exp 0",
                               bit_cnt, bit_err_cnt, pkt_cnt, pkt_err_cnt);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(128, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pkt_cnt !== 16'd1 || pkt_ok !== 1'b1 || bit_cnt !== 32'd107 || lock_5 !== 1'b1) begin
            errors++; $display("FAIL midrst_next got cnt %0d ok %0b bit %0d l5 %0b exp 1 1 107 1",
                               pkt_cnt, pkt_ok, bit_cnt, lock_5);
        end
    endtask

    task automatic test_qpsk();
        send(19, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lock_4 !== 1'b0) begin
            errors++; $display("FAIL lock4_beat19 got %0b exp 0", lock_4);
        end
        send(1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lock_4 !== 1'b1 || bit_cnt !== 32'd127) begin
            errors++; $display("FAIL lock4_beat20 got %0b bit %0d exp 1 127", lock_4, bit_cnt);
        end
        send(1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bit_cnt !== 32'd129) begin
            errors++; $display("FAIL qpsk_two_bits got %0d exp 129", bit_cnt);
        end
        send_sym();
        checks++;
        if (sym_err_cnt !== 16'd1 || bit_cnt !== 32'd131 || bit_err_cnt !== 32'd0) begin
            errors++; $display("FAIL qpsk_sym got sym %0d bit %0d err %0d exp 1 131 0",
                               sym_err_cnt, bit_cnt, bit_err_cnt);
        end
        send(106, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pkt_ok !== 1'b0 || pkt_err_cnt !== 16'd1 || bit_cnt !== 32'd343) begin
            errors++; $display("FAIL qpsk_pkt got ok %0b perr %0d bit %0d exp 0 1 343",
                               pkt_ok, pkt_err_cnt, bit_cnt);
        end
        send(9, 1'b0, 1'b0, 1'b0);
        send(1, 1'b1, 1'b0, 1'b0);
        send(118, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pkt_ok !== 1'b0 || pkt_err_cnt !== 16'd2 || pkt_cnt !== 16'd3) begin
            errors++; $display("FAIL mode_pkt got ok %0b perr %0d cnt %0d exp 0 2 3",
                               pkt_ok, pkt_err_cnt, pkt_cnt);
        end
        checks++;
        if (bit_cnt !== 32'd598 || bit_err_cnt !== 32'd0 || len_err !== 1'b0) begin
            errors++; $display("FAIL mode_bits got bit %0d err %0d len %0b exp 598 0 0",
                               bit_cnt, bit_err_cnt, len_err);
        end
    endtask

    task automatic test_gaps_clear();
        send(128, 1'b0, 1'b1, 1'b1);
        checks++;
        if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || pkt_cnt !== 16'd4) begin
            errors++; $display("FAIL gap_pkt got done %0b ok %0b cnt %0d exp 1 1 4",
                               pkt_done, pkt_ok, pkt_cnt);
        end
        checks++;
        if (bit_cnt !== 32'd854 || bit_err_cnt !== 32'd0 || pkt_err_cnt !== 16'd2) begin
            errors++; $display("FAIL gap_bits got bit %0d err %0d perr %0d exp 854 0 2",
                               bit_cnt, bit_err_cnt, pkt_err_cnt);
        end
        send(10, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        send_flip();
        clear = 1'b0;
        checks++;
        if (bit_err_cnt !== 32'd0 || bit_cnt !== 32'd0 || sym_err_cnt !== 16'd0 ||
            pkt_cnt !== 16'd0) begin
            errors++; $display("FAIL clear_wins got err %0d bit %0d sym %0d pkt %0d exp 0",
                               bit_err_cnt, bit_cnt, sym_err_cnt, pkt_cnt);
        end
        checks++;
        if (lock_5 !== 1'b1 || lock_4 !== 1'b1) begin
            errors++; $display("FAIL clear_lock got %0b %0b exp 1 1", lock_5, lock_4);
        end
        send(117, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bit_err_cnt !== 32'd2 || bit_cnt !== 32'd117 || sym_err_cnt !== 16'd0) begin
            errors++; $display("FAIL after_clear got err %0d bit %0d sym %0d exp 2 117 0",
                               bit_err_cnt, bit_cnt, sym_err_cnt);
        end
        checks++;
        if (pkt_ok !== 1'b0 || pkt_cnt !== 16'd1 || pkt_err_cnt !== 16'd1) begin
            errors++; $display("FAIL clear_pkt got ok %0b cnt %0d perr %0d exp 0 1 1",
                               pkt_ok, pkt_cnt, pkt_err_cnt);
        end
    endtask

    task automatic test_zero_len();
        payload_length = 16'd0;
        send(1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (len_err !== 1'b1 || pkt_ok !== 1'b0 || pkt_cnt !== 16'd2 ||
            pkt_err_cnt !== 16'd2) begin
            errors++; $display("FAIL zero_len got len %0b ok %0b cnt %0d perr %0d exp 1 0 2 2",
                               len_err, pkt_ok, pkt_cnt, pkt_err_cnt);
        end
        payload_length = 16'd128;
    endtask

    initial begin
        test_reset();
        test_clean_bpsk();
        test_bit_flip();
        test_length();
        test_reset_mid();
        test_qpsk();
        test_gaps_clear();
        test_zero_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
